// File: rtl/mbox_mem_arb_if.sv
// Requester/memory-side signal bundle for the MBOX core-memory arbiter.
// master drives requests and memory acks; slave is the arbiter.
interface mbox_mem_arb_if;
    logic        chanReq;
    logic        chanWrite;
    logic [21:0] chanAddr;
    logic        eboxReq;
    logic        eboxWrite;
    logic [21:0] eboxAddr;
    logic        sweepReq;
    logic [21:0] sweepAddr;
    logic        memAck;
    logic        nxmClr;
    logic [2:0]  grant;
    logic        memStart;
    logic        memWrite;
    logic [21:0] memAddr;
    logic        chanDone;
    logic        eboxDone;
    logic        sweepDone;
    logic        nxm;
    logic        nxmErr;

    modport master (
        output chanReq, chanWrite, chanAddr,
        output eboxReq, eboxWrite, eboxAddr,
        output sweepReq, sweepAddr,
        output memAck, nxmClr,
        input  grant, memStart, memWrite, memAddr,
        input  chanDone, eboxDone, sweepDone,
        input  nxm, nxmErr
    );

    modport slave (
        input  chanReq, chanWrite, chanAddr,
        input  eboxReq, eboxWrite, eboxAddr,
        input  sweepReq, sweepAddr,
        input  memAck, nxmClr,
        output grant, memStart, memWrite, memAddr,
        output chanDone, eboxDone, sweepDone,
        output nxm, nxmErr
    );
endinterface

// File: rtl/mbox_mem_arb.sv
// MBOX core-memory arbiter: CHAN > EBOX > SWEEP with a CHAN burst limit,
// one memory cycle at a time, tracked to memAck or NXM timeout.
module mbox_mem_arb #(
    parameter int CHAN_BURST = 4,
    parameter int TIMEOUT    = 255
) (
    input logic           mboxClk,
    input logic           CROBAR,
    mbox_mem_arb_if.slave bus
);

    localparam int RW = $clog2(CHAN_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_grant;
    logic [21:0] r_addr;
    logic        r_write;
    logic [RW-1:0] r_run;
    logic [7:0]  r_timer;
    logic [2:0]  r_done;
    logic        r_nxm;
    logic        r_err;

    logic        w_any_req;
    logic        w_ebox_turn;
    logic [2:0]  w_sel;
    logic [21:0] w_sel_addr;
    logic        w_sel_write;
    logic        w_launch;
    logic        w_fin;
    logic        w_tmo;

    assign w_any_req = bus.chanReq | bus.eboxReq | bus.sweepReq;
    // EBOX overrides CHAN once the channel has used up its burst allowance
    assign w_ebox_turn = bus.eboxReq && (r_run == RW'(CHAN_BURST));

    always_comb begin
        w_sel       = 3'b000;
        w_sel_addr  = 22'd0;
        w_sel_write = 1'b0;
        priority case (1'b1)
            w_ebox_turn: begin
                w_sel       = 3'b010;
                w_sel_addr  = bus.eboxAddr;
                w_sel_write = bus.eboxWrite;
            end
            bus.chanReq: begin
                w_sel       = 3'b001;
                w_sel_addr  = bus.chanAddr;
                w_sel_write = bus.chanWrite;
            end
            bus.eboxReq: begin
                w_sel       = 3'b010;
                w_sel_addr  = bus.eboxAddr;
                w_sel_write = bus.eboxWrite;
            end
            bus.sweepReq: begin
                w_sel       = 3'b100;
                w_sel_addr  = bus.sweepAddr;
                w_sel_write = 1'b1;
            end
            default: begin
                w_sel       = 3'b000;
                w_sel_addr  = 22'd0;
                w_sel_write = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_fin    = 1'b0;
        w_tmo    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_launch = 1'b1;
                    w_next   = S_START;
                end
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // an ack arriving on the last allowed cycle still completes cleanly
                if (bus.memAck) begin
                    w_fin  = 1'b1;
                    w_next = S_IDLE;
                end else if (r_timer == 8'(TIMEOUT - 1)) begin
                    w_fin  = 1'b1;
                    w_tmo  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mboxClk) begin
        if (CROBAR) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_addr  <= 22'd0;
            r_write <= 1'b0;
            r_run   <= '0;
            r_timer <= 8'd0;
            r_done  <= 3'b000;
            r_nxm   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fin ? r_grant : 3'b000;
            r_nxm   <= w_tmo;

            if (w_launch) begin
                r_grant <= w_sel;
                r_addr  <= w_sel_addr;
                r_write <= w_sel_write;
            end else if (w_fin) begin
                r_grant <= 3'b000;
                r_addr  <= 22'd0;
                r_write <= 1'b0;
            end

            if (r_state == S_START) begin
                r_timer <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + 8'd1;
            end

            if (r_state == S_IDLE) begin
                if (!bus.eboxReq) begin
                    r_run <= '0;
                end else if (w_launch && w_sel[0]) begin
                    if (r_run != RW'(CHAN_BURST)) begin
                        r_run <= r_run + RW'(1);
                    end
                end else if (w_launch) begin
                    r_run <= '0;
                end
            end

            if (w_tmo) begin
                r_err <= 1'b1;
            end else if (bus.nxmClr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.memStart  = (r_state == S_START);
    assign bus.memWrite  = r_write;
    assign bus.memAddr   = r_addr;
    assign bus.chanDone  = r_done[0];
    assign bus.eboxDone  = r_done[1];
    assign bus.sweepDone = r_done[2];
    assign bus.nxm       = r_nxm;
    assign bus.nxmErr    = r_err;

endmodule
